// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and line geometry for the cache/memory arbiter
package mem_arb_pkg;
    localparam int ADDR_W_DEF     = 64;
    localparam int DATA_W_DEF     = 64;
    localparam int LINE_BYTES_DEF = 64;
    localparam int BEATS          = LINE_BYTES_DEF / (DATA_W_DEF / 8);
    localparam int OFF_W          = $clog2(LINE_BYTES_DEF);
    localparam int CNT_W          = $clog2(BEATS) + 1;
    typedef enum logic [2:0] {IDLE, REQ, RDATA, WDATA, WRESP} arb_state_t;
    typedef enum logic {OWN_IC, OWN_DC} arb_owner_t;
endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant with a registered last winner
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_ic,
    input  logic req_dc,
    output logic gnt_ic,
    output logic gnt_dc
);
    arb_owner_t last_grant;
    always_comb begin
        gnt_dc = en && req_dc && (!req_ic || last_grant == OWN_IC);
        gnt_ic = en && req_ic && !gnt_dc;
    end
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= OWN_IC;
        else if (gnt_ic || gnt_dc)
            last_grant <= gnt_dc ? OWN_DC : OWN_IC;
    end
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serialises icache/dcache line transactions onto one memory bus
module cache_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LINE_BYTES = LINE_BYTES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    output logic              ic_resp_last,
    input  logic              dc_req_valid,
    input  logic              dc_req_write,
    input  logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_req_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wdata_ready,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,
    output logic              dc_resp_last,
    output logic              dc_wr_done,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic              m_req_write,
    output logic              m_wvalid,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_wready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_bvalid
);
    arb_state_t        state, state_n;
    arb_owner_t        owner;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              gnt_ic, gnt_dc;
    logic              last_beat;

    rr_arb2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .en     (state == IDLE && !reset),
        .req_ic (ic_req_valid),
        .req_dc (dc_req_valid),
        .gnt_ic (gnt_ic),
        .gnt_dc (gnt_dc)
    );

    assign last_beat = cnt == CNT_W'(BEATS - 1);

    // every output is forced low while reset is held, whatever state we were in
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        ic_req_ready   = 1'b0;
        ic_resp_valid  = 1'b0;
        ic_resp_data   = '0;
        ic_resp_last   = 1'b0;
        dc_req_ready   = 1'b0;
        dc_wdata_ready = 1'b0;
        dc_resp_valid  = 1'b0;
        dc_resp_data   = '0;
        dc_resp_last   = 1'b0;
        dc_wr_done     = 1'b0;
        m_req_valid    = 1'b0;
        m_req_addr     = '0;
        m_req_write    = 1'b0;
        m_wvalid       = 1'b0;
        m_wdata        = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    ic_req_ready = gnt_ic;
                    dc_req_ready = gnt_dc;
                    if (gnt_ic || gnt_dc)
                        state_n = REQ;
                end
                REQ: begin
                    m_req_valid = 1'b1;
                    m_req_addr  = addr;
                    m_req_write = wr;
                    if (m_req_ready) begin
                        cnt_n   = '0;
                        state_n = wr ? WDATA : RDATA;
                    end
                end
                RDATA: begin
                    if (m_rvalid) begin
                        ic_resp_valid = owner == OWN_IC;
                        dc_resp_valid = owner == OWN_DC;
                        ic_resp_data  = owner == OWN_IC ? m_rdata : '0;
                        dc_resp_data  = owner == OWN_DC ? m_rdata : '0;
                        ic_resp_last  = owner == OWN_IC && last_beat;
                        dc_resp_last  = owner == OWN_DC && last_beat;
                        cnt_n         = cnt + 1'b1;
                        if (last_beat)
                            state_n = IDLE;
                    end
                end
                WDATA: begin
                    m_wvalid       = 1'b1;
                    m_wdata        = dc_wdata;
                    dc_wdata_ready = m_wready;
                    if (m_wready) begin
                        cnt_n = cnt + 1'b1;
                        if (last_beat)
                            state_n = WRESP;
                    end
                end
                WRESP: begin
                    dc_wr_done = m_bvalid;
                    if (m_bvalid)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= OWN_IC;
            addr  <= '0;
            wr    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (gnt_ic || gnt_dc) begin
                owner <= gnt_dc ? OWN_DC : OWN_IC;
                addr  <= (gnt_dc ? dc_req_addr : ic_req_addr) & ~ADDR_W'(LINE_BYTES - 1);
                wr    <= gnt_dc & dc_req_write;
            end
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed scenario bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ic_req_valid = 1'b0;
    logic [AW-1:0] ic_req_addr = '0;
    logic          dc_req_valid = 1'b0;
    logic          dc_req_write = 1'b0;
    logic [AW-1:0] dc_req_addr = '0;
    logic [DW-1:0] dc_wdata = '0;
    logic          m_req_ready = 1'b0;
    logic          m_wready = 1'b0;
    logic          m_rvalid = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_bvalid = 1'b0;
    logic          ic_req_ready, ic_resp_valid, ic_resp_last;
    logic [DW-1:0] ic_resp_data, dc_resp_data, m_wdata;
    logic          dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_last, dc_wr_done;
    logic          m_req_valid, m_req_write, m_wvalid;
    logic [AW-1:0] m_req_addr;
    logic [3*DW+AW+10:0] all_out;

    int vecs = 0;
    int miss = 0;

    cache_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_req_ready   (ic_req_ready),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_data   (ic_resp_data),
        .ic_resp_last   (ic_resp_last),
        .dc_req_valid   (dc_req_valid),
        .dc_req_write   (dc_req_write),
        .dc_req_addr    (dc_req_addr),
        .dc_req_ready   (dc_req_ready),
        .dc_wdata       (dc_wdata),
        .dc_wdata_ready (dc_wdata_ready),
        .dc_resp_valid  (dc_resp_valid),
        .dc_resp_data   (dc_resp_data),
        .dc_resp_last   (dc_resp_last),
        .dc_wr_done     (dc_wr_done),
        .m_req_valid    (m_req_valid),
        .m_req_ready    (m_req_ready),
        .m_req_addr     (m_req_addr),
        .m_req_write    (m_req_write),
        .m_wvalid       (m_wvalid),
        .m_wdata        (m_wdata),
        .m_wready       (m_wready),
        .m_rvalid       (m_rvalid),
        .m_rdata        (m_rdata),
        .m_bvalid       (m_bvalid)
    );

    assign all_out = {ic_req_ready, ic_resp_valid, ic_resp_data, ic_resp_last,
                      dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data,
                      dc_resp_last, dc_wr_done, m_req_valid, m_req_addr,
                      m_req_write, m_wvalid, m_wdata};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ic_req_valid = 1'b0; ic_req_addr = '0;
        dc_req_valid = 1'b0; dc_req_write = 1'b0; dc_req_addr = '0; dc_wdata = '0;
        m_req_ready = 1'b0; m_wready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_bvalid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (3) cyc();
        ic_req_valid = 1'b1; dc_req_valid = 1'b1; m_rvalid = 1'b1; m_bvalid = 1'b1;
        #1;
        vecs++;
        if (all_out !== '0) begin miss++; $display("FAIL reset_hold: outputs=%h want 0", all_out); end
        clear_inputs();
        reset = 1'b0;
        cyc();
        #1;
        vecs++;
        if (all_out !== '0) begin miss++; $display("FAIL reset_idle: outputs=%h want 0", all_out); end
    endtask

    task automatic test_ic_only();
        cyc();
        ic_req_valid = 1'b1; ic_req_addr = 64'h1234;
        #1;
        vecs++;
        if ({ic_req_ready, dc_req_ready, m_req_valid} !== 3'b100) begin
            miss++; $display("FAIL ic_grant: ready_ic/ready_dc/mreq=%b want 100", {ic_req_ready, dc_req_ready, m_req_valid});
        end
        cyc();
        ic_req_valid = 1'b0; ic_req_addr = '0; m_req_ready = 1'b1;
        #1;
        vecs++;
        if ({m_req_valid, m_req_write, ic_req_ready, m_req_addr} !== {3'b100, 64'h1200}) begin
            miss++; $display("FAIL ic_req: valid/write/ready=%b addr=%h want 100 addr 1200", {m_req_valid, m_req_write, ic_req_ready}, m_req_addr);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            m_req_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 64'(i);
            #1;
            vecs++;
            if ({ic_resp_valid, ic_resp_last, dc_resp_valid, ic_resp_data} !== {1'b1, i == 7, 1'b0, 64'(i)}) begin
                miss++; $display("FAIL ic_beat%0d: v/last/dcv=%b data=%h want %b data %0d", i, {ic_resp_valid, ic_resp_last, dc_resp_valid}, ic_resp_data, {1'b1, i == 7, 1'b0}, i);
            end
        end
        cyc();
        m_rvalid = 1'b0;
        #1;
        vecs++;
        if (all_out !== '0) begin miss++; $display("FAIL ic_done_idle: outputs=%h want 0", all_out); end
    endtask

    task automatic test_alternation();
        do_reset();
        cyc();
        ic_req_valid = 1'b1; ic_req_addr = 64'h2040;
        dc_req_valid = 1'b1; dc_req_write = 1'b0; dc_req_addr = 64'h30bf;
        #1;
        vecs++;
        if ({ic_req_ready, dc_req_ready} !== 2'b01) begin
            miss++; $display("FAIL tie1_dc_first: ic/dc ready=%b want 01", {ic_req_ready, dc_req_ready});
        end
        cyc();
        dc_req_valid = 1'b0; m_req_ready = 1'b1;
        #1;
        vecs++;
        if ({m_req_valid, m_req_write, ic_req_ready, m_req_addr} !== {3'b100, 64'h3080}) begin
            miss++; $display("FAIL dc_req: valid/write/icready=%b addr=%h want 100 addr 3080", {m_req_valid, m_req_write, ic_req_ready}, m_req_addr);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            m_req_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 64'hd0 + 64'(i);
            #1;
            vecs++;
            if ({dc_resp_valid, dc_resp_last, ic_resp_valid, dc_resp_data} !== {1'b1, i == 7, 1'b0, 64'hd0 + 64'(i)}) begin
                miss++; $display("FAIL dc_beat%0d: v/last/icv=%b data=%h want %b data %h", i, {dc_resp_valid, dc_resp_last, ic_resp_valid}, dc_resp_data, {1'b1, i == 7, 1'b0}, 64'hd0 + 64'(i));
            end
        end
        cyc();
        m_rvalid = 1'b0;
        #1;
        vecs++;
        if ({ic_req_ready, dc_req_ready} !== 2'b10) begin
            miss++; $display("FAIL b2b_ic_grant: ic/dc ready=%b want 10", {ic_req_ready, dc_req_ready});
        end
        cyc();
        ic_req_valid = 1'b0; m_req_ready = 1'b1;
        #1;
        vecs++;
        if ({m_req_valid, m_req_addr} !== {1'b1, 64'h2040}) begin
            miss++; $display("FAIL ic2_req: valid=%b addr=%h want 1 addr 2040", m_req_valid, m_req_addr);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            m_req_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 64'he0 + 64'(i);
            #1;
            vecs++;
            if ({ic_resp_valid, ic_resp_last, dc_resp_valid, ic_resp_data} !== {1'b1, i == 7, 1'b0, 64'he0 + 64'(i)}) begin
                miss++; $display("FAIL ic2_beat%0d: v/last/dcv=%b data=%h", i, {ic_resp_valid, ic_resp_last, dc_resp_valid}, ic_resp_data);
            end
        end
        cyc();
        m_rvalid = 1'b0; ic_req_valid = 1'b1; dc_req_valid = 1'b1;
        #1;
        vecs++;
        if ({ic_req_ready, dc_req_ready} !== 2'b01) begin
            miss++; $display("FAIL tie2_dc_again: ic/dc ready=%b want 01", {ic_req_ready, dc_req_ready});
        end
        do_reset();
    endtask

    task automatic test_writeback();
        int pulses = 0;
        cyc();
        dc_req_valid = 1'b1; dc_req_write = 1'b1; dc_req_addr = 64'h1000;
        #1;
        vecs++;
        if ({ic_req_ready, dc_req_ready} !== 2'b01) begin
            miss++; $display("FAIL wb_grant: ic/dc ready=%b want 01", {ic_req_ready, dc_req_ready});
        end
        cyc();
        dc_req_valid = 1'b0; dc_req_write = 1'b0; m_req_ready = 1'b1;
        #1;
        vecs++;
        if ({m_req_valid, m_req_write, m_req_addr} !== {2'b11, 64'h1000}) begin
            miss++; $display("FAIL wb_req: valid/write=%b addr=%h want 11 addr 1000", {m_req_valid, m_req_write}, m_req_addr);
        end
        for (int c = 0; c < 3; c++) begin
            cyc();
            m_req_ready = 1'b0; m_wready = 1'b0; dc_wdata = 64'ha0;
            #1;
            pulses += int'(dc_wdata_ready);
            vecs++;
            if ({m_wvalid, dc_wdata_ready} !== 2'b10) begin
                miss++; $display("FAIL wb_stall%0d: wvalid/wready_out=%b want 10", c, {m_wvalid, dc_wdata_ready});
            end
        end
        for (int c = 0; c < 8; c++) begin
            cyc();
            m_wready = 1'b1; dc_wdata = 64'ha0 + 64'(c);
            #1;
            pulses += int'(dc_wdata_ready);
            vecs++;
            if ({m_wvalid, m_wdata} !== {1'b1, 64'ha0 + 64'(c)}) begin
                miss++; $display("FAIL wb_beat%0d: wvalid=%b wdata=%h want 1 %h", c, m_wvalid, m_wdata, 64'ha0 + 64'(c));
            end
        end
        for (int c = 0; c < 2; c++) begin
            cyc();
            #1;
            pulses += int'(dc_wdata_ready);
            vecs++;
            if ({m_wvalid, dc_wdata_ready, dc_wr_done} !== 3'b000) begin
                miss++; $display("FAIL wb_wait%0d: wvalid/wready_out/done=%b want 000", c, {m_wvalid, dc_wdata_ready, dc_wr_done});
            end
        end
        cyc();
        m_wready = 1'b0; m_bvalid = 1'b1;
        #1;
        vecs++;
        if (dc_wr_done !== 1'b1) begin miss++; $display("FAIL wb_done: dc_wr_done=%b want 1", dc_wr_done); end
        cyc();
        m_bvalid = 1'b0;
        #1;
        vecs++;
        if (all_out !== '0) begin miss++; $display("FAIL wb_done_pulse: outputs=%h want 0", all_out); end
        vecs++;
        if (pulses != 8) begin miss++; $display("FAIL wb_pulse_count: %0d want 8", pulses); end
    endtask

    task automatic test_stall();
        logic [12:0] pat = 13'b1101101001101;
        int n = 0;
        cyc();
        ic_req_valid = 1'b1; ic_req_addr = 64'h4abc;
        #1;
        vecs++;
        if (ic_req_ready !== 1'b1) begin miss++; $display("FAIL stall_grant: ic_req_ready=%b want 1", ic_req_ready); end
        for (int c = 0; c < 5; c++) begin
            cyc();
            ic_req_valid = 1'b0; ic_req_addr = '0;
            #1;
            vecs++;
            if ({m_req_valid, m_req_addr} !== {1'b1, 64'h4a80}) begin
                miss++; $display("FAIL stall_hold%0d: valid=%b addr=%h want 1 addr 4a80", c, m_req_valid, m_req_addr);
            end
        end
        cyc();
        m_req_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            cyc();
            m_req_ready = 1'b0; m_rvalid = pat[c]; m_rdata = 64'h50 + 64'(n);
            #1;
            vecs++;
            if ({ic_resp_valid, ic_resp_last, m_req_valid} !== {pat[c], pat[c] && n == 7, 1'b0}) begin
                miss++; $display("FAIL gap_cycle%0d: v/last/mreq=%b want %b", c, {ic_resp_valid, ic_resp_last, m_req_valid}, {pat[c], pat[c] && n == 7, 1'b0});
            end
            if (pat[c]) n++;
        end
        cyc();
        m_rvalid = 1'b0;
        #1;
        vecs++;
        if (all_out !== '0) begin miss++; $display("FAIL gap_done_idle: outputs=%h want 0", all_out); end
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        int lasts = 0;
        cyc();
        ic_req_valid = 1'b1; ic_req_addr = 64'h5000;
        cyc();
        ic_req_valid = 1'b0; m_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            m_req_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 64'(i);
        end
        cyc();
        m_rdata = 64'd4; reset = 1'b1;
        #1;
        vecs++;
        if (all_out !== '0) begin miss++; $display("FAIL rst_mid_hold: outputs=%h want 0", all_out); end
        cyc();
        reset = 1'b0; m_rvalid = 1'b0;
        #1;
        vecs++;
        if (all_out !== '0) begin miss++; $display("FAIL rst_mid_idle: outputs=%h want 0", all_out); end
        cyc();
        ic_req_valid = 1'b1; ic_req_addr = 64'h6008;
        #1;
        vecs++;
        if (ic_req_ready !== 1'b1) begin miss++; $display("FAIL rst_fresh_grant: ic_req_ready=%b want 1", ic_req_ready); end
        cyc();
        ic_req_valid = 1'b0; m_req_ready = 1'b1;
        #1;
        vecs++;
        if (m_req_addr !== 64'h6000) begin miss++; $display("FAIL rst_fresh_addr: %h want 6000", m_req_addr); end
        for (int i = 0; i < 8; i++) begin
            cyc();
            m_req_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 64'h60 + 64'(i);
            #1;
            beats += int'(ic_resp_valid);
            lasts += int'(ic_resp_last);
            vecs++;
            if (ic_resp_last !== (i == 7)) begin
                miss++; $display("FAIL rst_fresh_last%0d: last=%b want %b", i, ic_resp_last, i == 7);
            end
        end
        cyc();
        m_rvalid = 1'b0;
        vecs++;
        if ({beats, lasts} !== {32'd8, 32'd1}) begin
            miss++; $display("FAIL rst_fresh_count: beats=%0d lasts=%0d want 8 and 1", beats, lasts);
        end
    endtask

    task automatic test_spurious();
        for (int c = 0; c < 3; c++) begin
            cyc();
            m_rvalid = 1'b1; m_bvalid = 1'b1; m_wready = 1'b1; m_req_ready = 1'b1; m_rdata = 64'hdead;
            #1;
            vecs++;
            if (all_out !== '0) begin miss++; $display("FAIL spurious%0d: outputs=%h want 0", c, all_out); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ic_only();
        test_alternation();
        test_writeback();
        test_stall();
        test_reset_mid();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of icache and dcache. Arbitrates their line-refill and dcache write-back requests onto the single shared memory bus.
- Serialises one line transaction at a time and routes read beats back to the owning cache.
- Applies two-way round-robin so neither cache starves.

Parameters:
- ADDR_W, 64, address width of caches and bus.
- DATA_W, 64, beat width of caches and bus.
- LINE_BYTES, 64, cache line size. Derived localparams: BEATS = LINE_BYTES/(DATA_W/8) = 8 and OFF_W = log2(LINE_BYTES).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- ic_req_valid  in  1  icache refill request.
- ic_req_addr  in  ADDR_W  refill address.
- ic_req_ready  out  1  request accepted this cycle.
- ic_resp_valid  out  1  read beat to icache.
- ic_resp_data  out  DATA_W  beat data.
- ic_resp_last  out  1  final beat of line.
- dc_req_valid  in  1  dcache request.
- dc_req_write  in  1  1 = write-back, 0 = refill.
- dc_req_addr  in  ADDR_W  line address.
- dc_req_ready  out  1  request accepted this cycle.
- dc_wdata  in  DATA_W  current write-back beat.
- dc_wdata_ready  out  1  beat consumed; dcache advances to next beat.
- dc_resp_valid  out  1  read beat to dcache.
- dc_resp_data  out  DATA_W  beat data.
- dc_resp_last  out  1  final beat of line.
- dc_wr_done  out  1  one-cycle pulse, write-back complete.
- m_req_valid  out  1  bus request.
- m_req_ready  in  1  bus accepts request.
- m_req_addr  out  ADDR_W  line-aligned address.
- m_req_write  out  1  request type.
- m_wvalid  out  1  write beat valid.
- m_wdata  out  DATA_W  write beat.
- m_wready  in  1  bus accepts write beat.
- m_rvalid  in  1  read beat valid.
- m_rdata  in  DATA_W  read beat.
- m_bvalid  in  1  write response.

Behaviour:
- Clocking and reset:
  - Clock port is clk; reset port is reset. Single clock; reset is synchronous, active-high, sampled on the rising edge of clk.
  - On reset: state=IDLE, beat_cnt=0, owner=IC, last_grant=IC, latched addr/write=0.
  - All outputs read 0 while reset is asserted and in the following IDLE cycle. The first tie after reset therefore goes to DC.
- FSM states: IDLE, REQ, RDATA, WDATA, WRESP.
- IDLE:
  - Request from exactly one client: that client is granted.
  - Both clients requesting: grant the client != last_grant.
  - In the grant cycle, the winner's *_req_ready=1 (combinational on valid). Latch the address with low OFF_W bits forced to 0. Latch write (dc_req_write for DC, 0 for IC). Set owner=winner and last_grant=winner. Next state is REQ.
  - Requests are sampled only in IDLE. Clients must hold valid and addr stable until ready.
- REQ:
  - m_req_valid=1 with the latched addr/write. m_req_valid first asserts in cycle N+1 after the grant handshake in cycle N.
  - On m_req_ready: beat_cnt=0; next state is WDATA if write, else RDATA.
- RDATA:
  - m_rvalid is passed combinationally to the owner's resp_valid, with m_rdata on its resp_data.
  - Each beat increments beat_cnt. On beat BEATS-1, resp_last=1 in that same cycle, then next state is IDLE.
  - Non-owner resp_valid stays 0.
- WDATA:
  - m_wvalid=1 and m_wdata=dc_wdata.
  - dc_wdata_ready = m_wvalid & m_wready.
  - After BEATS accepted beats, next state is WRESP.
- WRESP:
  - Wait for m_bvalid. On m_bvalid, pulse dc_wr_done for 1 cycle (same cycle), then next state is IDLE.
- Back-to-back: a new grant is possible in the cycle after returning to IDLE. There is no request pipelining; exactly one transaction is outstanding.
- Ignored bus inputs: m_rvalid outside RDATA, m_wready outside WDATA, and m_bvalid outside WRESP.
- Reset mid-transaction: the transaction is abandoned immediately; no last/done is emitted. Clients and bus are reset by the same signal.
- beat_cnt is log2(BEATS) bits wide plus 1 guard bit and never wraps within a transaction.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, REQ, RDATA, WDATA, WRESP};
  - owner enum arb_owner_t {OWN_IC, OWN_DC};
  - localparams BEATS and OFF_W.
- One natural sub-module: rr_arb2, the two-input round-robin grant (combinational pick plus registered last_grant).

Test Plan:
- IC only: ic_req addr 0x1234 -> ic_req_ready 1 cycle; next cycle m_req_addr=0x1200, m_req_write=0; 8 m_rvalid beats 0..7 -> ic_resp_data 0..7, ic_resp_last on beat 7 only; dc_resp_valid stays 0.
- Simultaneous IC and DC refill after reset -> DC granted first; IC granted on the next IDLE; a third simultaneous pair -> DC again (alternation).
- DC write-back addr 0x1000, m_wready held low 3 cycles then high -> exactly 8 dc_wdata_ready pulses; m_wdata matches dc_wdata; m_bvalid 2 cycles later -> single dc_wr_done pulse.
- Stall the bus: m_req_ready low 5 cycles -> m_req_valid and m_req_addr held stable; gaps in m_rvalid -> beat count unaffected.
- Reset asserted on read beat 4 -> next cycle all outputs 0, state IDLE; a fresh IC request completes normally with 8 beats.
- Spurious m_rvalid and m_bvalid in IDLE -> no resp_valid and no dc_wr_done.
